mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers, directly downstream of the ALU operand mux.
- Consumes the selected operands (in1 = rs path, in2 = rt path) for MULT, MULTU, DIV and DIVU, and serves MTHI/MTLO writes.
- Exposes HI/LO for MFHI/MFLO writeback.
- Provides a start/busy/done handshake so the control unit can stall while an operation runs.

Parameters:
- WIDTH, 32, operand width; HI/LO are WIDTH bits each.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- RST_n  input  1  asynchronous active-low reset.
- start  input  1  request an operation; sampled only when idle.
- op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- in1  input  WIDTH  multiplicand or dividend.
- in2  input  WIDTH  multiplier or divisor.
- hiWrite  input  1  MTHI: load wrData into HI.
- loWrite  input  1  MTLO: load wrData into LO.
- wrData  input  WIDTH  data for MTHI/MTLO.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; HI/LO hold the new result.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Clock and reset: one clock CLK; reset RST_n is asynchronous, active-low.
- Reset (RST_n=0, asynchronous, any state): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, internal operand registers=0. An operation in progress is abandoned and HI/LO are not updated.
- State IDLE:
  - start=1 at edge E0: latch magnitudes of in1/in2 (signed ops take two's-complement absolute value), latch the result-sign flags and op, clear counter, go to RUN.
  - From the cycle after E0: busy=1.
- State RUN: one iteration per edge, counter increments.
  - Multiply: shift-add over a 2*WIDTH accumulator.
  - Divide: restoring, one quotient bit per edge.
  - At edge E32 (the WIDTH-th RUN edge):
    - Sign-fix the result, write HI/LO, return to IDLE.
    - done=1 and busy=0 for exactly the one cycle following E32.
- Latency: start sampled at E0 -> hi/lo valid and done=1 after E32. busy is high for exactly 32 cycles.
- Result mapping:
  - Multiply: {hi,lo} = 64-bit product. Signed product is negated when the operand signs differ.
  - Divide: lo = quotient, hi = remainder.
  - Signed divide: quotient negated when signs differ; remainder takes the sign of the dividend.
- Divide by zero:
  - DIVU: lo=FFFFFFFF, hi=in1.
  - DIV: lo=FFFFFFFF, hi=in1 (original signed value).
- Signed overflow, DIV 80000000 / FFFFFFFF: lo=80000000, hi=0.
- start while busy=1: ignored; the running operation continues unchanged.
- start in the done cycle: accepted, since the state is IDLE. The new operation begins and done still pulses for the previous result.
- hiWrite/loWrite:
  - Honoured only when state=IDLE and start=0; applied at that edge.
  - Ignored while busy.
  - If start=1 and hiWrite/loWrite=1 in the same idle cycle, start wins and the writes are dropped.
  - hiWrite and loWrite may both be 1 in the same cycle; both HI and LO load wrData.
- hi/lo hold their value at all times except at a completing edge, a permitted MT write, or reset.
- in1/in2/op changes after E0 have no effect on the running operation.

Test Plan:
- Reset: hold RST_n=0 mid-RUN of MULTU -> busy=0, done=0, hi=lo=0 immediately, without waiting for a clock edge. The next start runs normally.
- MULTU in1=FFFFFFFF, in2=2 -> busy=1 for 32 cycles, then done=1 with hi=00000001, lo=FFFFFFFE. MULT with the same operands -> hi=FFFFFFFF, lo=FFFFFFFE.
- DIV in1=-7 (FFFFFFF9), in2=2 -> lo=FFFFFFFD (-3), hi=FFFFFFFF (-1). DIVU in1=20, in2=3 -> lo=6, hi=2.
- DIVU in1=10, in2=0 -> lo=FFFFFFFF, hi=0000000A. DIV in1=80000000, in2=FFFFFFFF -> lo=80000000, hi=0.
- start re-asserted at cycle 10 of a MULTU 10*5 with in1 changed to 99 -> ignored; result hi=0, lo=50 after 32 cycles.
- MT writes:
  - Idle hiWrite=1, wrData=1234 -> hi=1234 next edge.
  - hiWrite while busy -> no effect.
  - start plus loWrite in the same idle cycle -> op starts and lo is taken from the result, not wrData.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Multiply is shift-add over a 2*WIDTH accumulator. Divide is restoring, one
// quotient bit per clock. Operands are reduced to magnitudes when accepted,
// and the result is sign-fixed on the final iteration edge.
//
// Handshake: start is taken only while the unit is idle (busy=0). The edge that
// accepts start is E0. busy is high for the WIDTH cycles after E0. done pulses
// for the single cycle after the last iteration, and HI/LO already hold the new
// result in that cycle. A start seen while busy is ignored. A start seen during
// the done cycle is accepted.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             hiWrite,
    input  logic             loWrite,
    input  logic [WIDTH-1:0] wrData,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} stateT;

    stateT                 state, stateNext;
    logic [CNT_W-1:0]      cnt;
    logic                  isDiv, negRes, negRem, divZero;
    logic [WIDTH-1:0]      opnd;      // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0]    acc;       // product, or {remainder, dividend/quotient}

    logic                  aNeg, bNeg, lastIter;
    logic [WIDTH-1:0]      aMagIn, bMagIn;
    logic [WIDTH:0]        mulSum, divShift;
    logic                  divGe;
    logic [WIDTH-1:0]      divDiff, quot, rem;
    logic [2*WIDTH-1:0]    accStep, prodFix;
    logic [WIDTH-1:0]      resHi, resLo;

    // Operand magnitudes and signs. op[0]=0 selects the signed variants.
    always_comb begin
        aNeg   = ~op[0] & in1[WIDTH-1];
        bNeg   = ~op[0] & in2[WIDTH-1];
        aMagIn = aNeg ? -in1 : in1;
        bMagIn = bNeg ? -in2 : in2;
    end

    // One multiply or divide iteration, plus the sign-fixed final result.
    always_comb begin
        lastIter = (cnt == CNT_W'(WIDTH - 1));
        mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        divShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        divGe    = (divShift >= {1'b0, opnd});
        // The true difference is below the divisor, so WIDTH bits are enough.
        divDiff  = divShift[WIDTH-1:0] - opnd;
        if (isDiv)
            accStep = {(divGe ? divDiff : divShift[WIDTH-1:0]), acc[WIDTH-2:0], divGe};
        else
            accStep = {mulSum, acc[WIDTH-1:1]};
        prodFix = negRes ? -accStep : accStep;
        quot    = accStep[WIDTH-1:0];
        rem     = accStep[2*WIDTH-1:WIDTH];
        if (isDiv) begin
            // With a zero divisor the remainder equals |dividend|. Restoring its
            // sign gives back the original in1.
            resLo = divZero ? '1 : (negRes ? -quot : quot);
            resHi = negRem ? -rem : rem;
        end else begin
            resLo = prodFix[WIDTH-1:0];
            resHi = prodFix[2*WIDTH-1:WIDTH];
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) state <= IDLE;
        else        state <= stateNext;
    end

    // Next-state logic: leave IDLE on start and return after WIDTH iterations.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (start)    stateNext = RUN;
            RUN:     if (lastIter) stateNext = IDLE;
            default:               stateNext = IDLE;
        endcase
    end

    assign busy = (state == RUN);

    // Datapath: operand capture, iteration, result write-back and MTHI/MTLO.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            cnt     <= '0;
            isDiv   <= 1'b0;
            negRes  <= 1'b0;
            negRem  <= 1'b0;
            divZero <= 1'b0;
            opnd    <= '0;
            acc     <= '0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    cnt     <= '0;
                    isDiv   <= op[1];
                    negRes  <= aNeg ^ bNeg;
                    negRem  <= aNeg;
                    divZero <= (in2 == '0);
                    opnd    <= op[1] ? bMagIn : aMagIn;
                    acc     <= op[1] ? {{WIDTH{1'b0}}, aMagIn} : {{WIDTH{1'b0}}, bMagIn};
                end else begin
                    if (hiWrite) hi <= wrData;
                    if (loWrite) lo <= wrData;
                end
            end else begin
                acc <= accStep;
                cnt <= cnt + 1'b1;
                if (lastIter) begin
                    hi   <= resHi;
                    lo   <= resLo;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: a vector table, hand-written corner sequences and
// random operations, all scored against an expected-result queue.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RST_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic         hiWrite = 1'b0;
  logic         loWrite = 1'b0;
  logic [W-1:0] wrData = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .CLK(CLK), .RST_n(RST_n), .start(start), .op(op), .in1(in1), .in2(in2),
    .hiWrite(hiWrite), .loWrite(loWrite), .wrData(wrData),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] expQ[$];

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] expHi;
    logic [W-1:0] expLo;
  } vecT;

  vecT vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model built on wide native arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, q, r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (o)
      2'b00: return sa * sb;
      2'b01: return {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // driver: call at a falling edge; start is held over exactly one rising edge
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp);
    start = 1'b1;
    op    = o;
    in1   = a;
    in2   = b;
    expQ.push_back(exp);
    @(posedge CLK);
    #1;
    start = 1'b0;
  endtask

  // monitor: count busy cycles until done, then score hi/lo against the queue
  task automatic collect(input string name, input int pre);
    int busyCnt = pre;
    bit seen = 1'b0;
    logic [63:0] e;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge CLK);
      if (done) seen = 1'b1;
      else if (busy) busyCnt++;
    end
    check({name, "_done"}, {63'b0, done}, 64'd1);
    check({name, "_busyCycles"}, busyCnt, 64'd32);
    check({name, "_busyAtDone"}, {63'b0, busy}, 64'd0);
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_queue: got empty expected entry", name);
    end else begin
      e = expQ.pop_front();
      check({name, "_hi"}, {32'b0, hi}, {32'b0, e[63:32]});
      check({name, "_lo"}, {32'b0, lo}, {32'b0, e[31:0]});
    end
  endtask

  initial begin
    int pre;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    vecs[0]  = '{2'b01, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE};
    vecs[1]  = '{2'b00, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[2]  = '{2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{2'b11, 32'd20,        32'd3,        32'd2,         32'd6};
    vecs[4]  = '{2'b11, 32'd10,        32'd0,        32'h0000_000A, 32'hFFFF_FFFF};
    vecs[5]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000};
    vecs[6]  = '{2'b10, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[7]  = '{2'b00, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[8]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD};
    vecs[9]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};
    vecs[10] = '{2'b11, 32'hFFFF_FFFF, 32'd1,        32'h0,         32'hFFFF_FFFF};
    vecs[11] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};

    // reset state
    repeat (2) @(negedge CLK);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_hi", {32'b0, hi}, 64'd0);
    check("rst_lo", {32'b0, lo}, 64'd0);
    RST_n = 1'b1;

    // vector table
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      issue(vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].expHi, vecs[i].expLo});
      collect($sformatf("vec%0d", i), 0);
    end

    // asynchronous reset in the middle of a MULTU
    @(negedge CLK);
    issue(2'b01, 32'h0000_FFFF, 32'h0000_FFFF, 64'h0);
    repeat (10) @(negedge CLK);
    RST_n = 1'b0;
    #1;
    check("midRst_busy", {63'b0, busy}, 64'd0);
    check("midRst_done", {63'b0, done}, 64'd0);
    check("midRst_hi", {32'b0, hi}, 64'd0);
    check("midRst_lo", {32'b0, lo}, 64'd0);
    expQ.delete();
    @(negedge CLK);
    RST_n = 1'b1;
    @(negedge CLK);
    check("postRst_busy", {63'b0, busy}, 64'd0);
    issue(2'b01, 32'd1000, 32'd1000, 64'd1000000);
    collect("postRst", 0);

    // start re-asserted while busy with different operands is ignored
    @(negedge CLK);
    issue(2'b01, 32'd10, 32'd5, 64'd50);
    pre = 0;
    repeat (9) begin
      @(negedge CLK);
      if (busy) pre++;
    end
    start = 1'b1;
    in1   = 32'd99;
    in2   = 32'd7;
    op    = 2'b10;
    @(negedge CLK);
    if (busy) pre++;
    start = 1'b0;
    collect("ignStart", pre);
    @(negedge CLK);
    check("ignStart_idleAfter", {63'b0, busy}, 64'd0);

    // MTHI / MTLO in idle
    hiWrite = 1'b1;
    wrData  = 32'h1234;
    @(negedge CLK);
    hiWrite = 1'b0;
    check("mtHi_hi", {32'b0, hi}, 64'h1234);
    check("mtHi_loHeld", {32'b0, lo}, 64'd50);
    hiWrite = 1'b1;
    loWrite = 1'b1;
    wrData  = 32'hABCD;
    @(negedge CLK);
    hiWrite = 1'b0;
    loWrite = 1'b0;
    check("mtBoth_hi", {32'b0, hi}, 64'hABCD);
    check("mtBoth_lo", {32'b0, lo}, 64'hABCD);

    // MT writes while busy have no effect
    issue(2'b01, 32'd3, 32'd4, 64'd12);
    pre = 0;
    hiWrite = 1'b1;
    loWrite = 1'b1;
    wrData  = 32'hDEAD;
    repeat (4) begin
      @(negedge CLK);
      if (busy) pre++;
    end
    check("mtBusy_hiHeld", {32'b0, hi}, 64'hABCD);
    check("mtBusy_loHeld", {32'b0, lo}, 64'hABCD);
    hiWrite = 1'b0;
    loWrite = 1'b0;
    collect("mtBusy", pre);

    // start and loWrite in the same idle cycle: start wins
    @(negedge CLK);
    loWrite = 1'b1;
    wrData  = 32'hFFFF;
    issue(2'b01, 32'd6, 32'd7, 64'd42);
    loWrite = 1'b0;
    check("startWins_loHeld", {32'b0, lo}, 64'd12);
    collect("startWins", 0);

    // back-to-back: new start issued during the done cycle
    @(negedge CLK);
    issue(2'b00, 32'hFFFF_FFFB, 32'd3, model(2'b00, 32'hFFFF_FFFB, 32'd3));
    collect("b2bFirst", 0);
    issue(2'b11, 32'd100, 32'd7, {32'd2, 32'd14});
    collect("b2bSecond", 0);

    // random operations against the reference model
    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      @(negedge CLK);
      issue(ro, ra, rb, model(ro, ra, rb));
      collect($sformatf("rnd%0d", i), 0);
    end

    // report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
